regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/riscv_pkg.sv | 6 +
 rtl/regfile_scoreboard.sv | 25 ++
 rtl/regfile_mp.sv | 84 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file geometry for the integer core.
// No ports; exports REG_ADDR_W (register address width) and NUM_REGS (register count).
package riscv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write scoreboard, one busy bit per register.
// Ports: clock, reset (sync, active-high); busy_set/busy_set_addr mark a register
// pending; write_enable/write_addr clear it; busy_vector is the live scoreboard.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  busy_set,
    input  logic [REG_ADDR_W-1:0] busy_set_addr,
    input  logic                  write_enable,
    input  logic [REG_ADDR_W-1:0] write_addr,
    output logic [NUM_REGS-1:0]   busy_vector
);
    logic [NUM_REGS-1:0] set_mask, clr_mask, keep_mask;
    // x0 can never become pending when it is hardwired
    assign keep_mask = (ZERO_REG != 0) ? {{(NUM_REGS-1){1'b1}}, 1'b0} : '1;
    assign set_mask  = (NUM_REGS'(busy_set) << busy_set_addr) & keep_mask;
    assign clr_mask  = NUM_REGS'(write_enable) << write_addr;
    // set is applied after clear so a same-address set wins
    always_ff @(posedge clock)
        busy_vector <= reset ? '0 : (busy_vector & ~clr_mask) | set_mask;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 32-entry register file, one write port, NUM_READ registered read ports.
// Ports: clock, reset (sync, active-high); write_enable/write_addr/write_data commit a
// write; busy_set/busy_set_addr mark a register pending; read_en/read_addr (flat, 5 bits
// per port) request reads; read_data/read_valid/read_busy are registered one cycle later;
// busy_vector is the live scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-edge write data to readers.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             write_enable,
    input  logic [REG_ADDR_W-1:0]            write_addr,
    input  logic [WORD_SIZE-1:0]             write_data,
    input  logic                             busy_set,
    input  logic [REG_ADDR_W-1:0]            busy_set_addr,
    input  logic [NUM_READ-1:0]              read_en,
    input  logic [REG_ADDR_W*NUM_READ-1:0]   read_addr,
    output logic [WORD_SIZE*NUM_READ-1:0]    read_data,
    output logic [NUM_READ-1:0]              read_valid,
    output logic [NUM_READ-1:0]              read_busy,
    output logic [NUM_REGS-1:0]              busy_vector
);
    logic [WORD_SIZE-1:0]  regs [NUM_REGS];
    logic [WORD_SIZE-1:0]  d_n  [NUM_READ];
    logic [NUM_READ-1:0]   b_n;
    logic [REG_ADDR_W-1:0] ra;
    logic                  zr, hit, wz;

    regfile_scoreboard #(.ZERO_REG(ZERO_REG)) u_sb (
        .clock         (clock),
        .reset         (reset),
        .busy_set      (busy_set),
        .busy_set_addr (busy_set_addr),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .busy_vector   (busy_vector)
    );

    assign wz = (ZERO_REG != 0) && write_addr == '0;

    always_ff @(posedge clock)
        if (reset)
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (write_enable && !wz)
            regs[write_addr] <= write_data;

    // busy_vector here is the pre-edge value, so same-edge set/clear are not seen
    always_comb begin
        ra  = '0;
        zr  = 1'b0;
        hit = 1'b0;
        b_n = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            ra = read_addr[p*REG_ADDR_W +: REG_ADDR_W];
            zr = (ZERO_REG != 0) && ra == '0;
`ifdef REGFILE_BYPASS_EN
            hit = write_enable && ra == write_addr && ra != '0;
`else
            hit = 1'b0;
`endif
            d_n[p] = zr ? '0 : hit ? write_data : regs[ra];
            b_n[p] = !zr && !hit && busy_vector[ra];
        end
    end

    always_ff @(posedge clock)
        if (reset) begin
            read_data  <= '0;
            read_valid <= '0;
            read_busy  <= '0;
        end else begin
            read_valid <= read_en;
            for (int p = 0; p < NUM_READ; p++)
                if (read_en[p]) begin
                    read_data[p*WORD_SIZE +: WORD_SIZE] <= d_n[p];
                    read_busy[p]                        <= b_n[p];
                end
        end
endmodule
